// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter running one registered external bus transaction per grant
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_m0_req,
    input  logic              i_m0_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [DATA_W-1:0] i_m0_wdata,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    output logic [DATA_W-1:0] o_m0_rdata,
    input  logic              i_m1_req,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m1_wdata,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [DATA_W-1:0] o_m1_rdata,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready,
    output logic              o_owner,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    localparam int CNT_W = $clog2(TIMEOUT + 2);
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    logic              sel;
    logic              bus_clk_q, bus_clk_d;
    logic              bus_we_q, bus_we_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [1:0]        ack_q, ack_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata_q [2];
    logic [DATA_W-1:0] rdata_d [2];
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        owner_d = owner_q;
        addr_d  = addr_q;
        data_d  = data_q;
        bus_we_d = bus_we_q;
        ack_d   = '0;
        err_d   = '0;
        rdata_d = rdata_q;
        sel     = (i_m0_req && i_m1_req) ? !last_q : i_m1_req;
        case (state_q)
            IDLE: if (i_m0_req || i_m1_req) begin
                state_d  = ISSUE;
                last_d   = sel;
                owner_d  = sel;
                bus_we_d = sel ? i_m1_we : i_m0_we;
                addr_d   = sel ? i_m1_addr : i_m0_addr;
                data_d   = sel ? i_m1_wdata : i_m0_wdata;
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (i_bus_data_ready) begin
                state_d        = DONE;
                ack_d[owner_q] = 1'b1;
                if (!bus_we_q) rdata_d[owner_q] = i_bus_data;
            end else begin
                cnt_d = cnt_q + 1'b1;
                if (TIMEOUT != 0 && cnt_d == CNT_W'(TIMEOUT)) begin
                    state_d          = DONE;
                    err_d[owner_q]   = 1'b1;
                    rdata_d[owner_q] = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        bus_we_d  = (state_d == ISSUE || state_d == WAIT) && bus_we_d;
        bus_clk_d = state_d == ISSUE;
        busy_d    = state_d != IDLE;
    end
    always_ff @(posedge i_cpu_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= 1'b1;
            owner_q   <= 1'b0;
            bus_clk_q <= 1'b0;
            bus_we_q  <= 1'b0;
            busy_q    <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            ack_q     <= '0;
            err_q     <= '0;
            rdata_q   <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            bus_clk_q <= bus_clk_d;
            bus_we_q  <= bus_we_d;
            busy_q    <= busy_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            rdata_q   <= rdata_d;
        end
    end
    assign o_m0_ack   = ack_q[0];
    assign o_m1_ack   = ack_q[1];
    assign o_m0_err   = err_q[0];
    assign o_m1_err   = err_q[1];
    assign o_m0_rdata = rdata_q[0];
    assign o_m1_rdata = rdata_q[1];
    assign o_bus_clk  = bus_clk_q;
    assign o_bus_we   = bus_we_q;
    assign o_bus_addr = addr_q;
    assign o_bus_data = data_q;
    assign o_owner    = owner_q;
    assign o_busy     = busy_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed and randomized transactions checked against a transaction-level arbiter model
module tb_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_ack, m0_err, m1_ack, m1_err;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bus_clk, bus_we, owner, busy;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata = '0;
  logic          bus_ready = 1'b0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic          m_last;
  logic [DW-1:0] m_rd [2];
  logic          in_done = 1'b0;
  always #5 clk = ~clk;
  bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .i_cpu_clk(clk), .i_rst(rst),
    .i_m0_req(m0_req), .i_m0_we(m0_we), .i_m0_addr(m0_addr), .i_m0_wdata(m0_wdata),
    .o_m0_ack(m0_ack), .o_m0_err(m0_err), .o_m0_rdata(m0_rdata),
    .i_m1_req(m1_req), .i_m1_we(m1_we), .i_m1_addr(m1_addr), .i_m1_wdata(m1_wdata),
    .o_m1_ack(m1_ack), .o_m1_err(m1_err), .o_m1_rdata(m1_rdata),
    .o_bus_clk(bus_clk), .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_data(bus_wdata),
    .i_bus_data(bus_rdata), .i_bus_data_ready(bus_ready),
    .o_owner(owner), .o_busy(busy)
  );
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic txn(input logic r0, input logic r1, input logic we0, input logic we1,
                     input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                     input logic [DW-1:0] d0, input logic [DW-1:0] d1, input int delay);
    logic          w, we_e, ok, fin;
    logic [AW-1:0] a_e;
    logic [DW-1:0] d_e, rd;
    int            k;
    m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
    if (in_done) begin
      step();
      chk("idle_busy", busy, 1'b0);
      chk("idle_pulses", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
      chk("idle_we", bus_we, 1'b0);
    end
    w    = (r0 && r1) ? !m_last : r1;
    we_e = w ? we1 : we0;
    a_e  = w ? a1 : a0;
    d_e  = w ? d1 : d0;
    step();
    chk("issue_strobe", bus_clk, 1'b1);
    chk("issue_owner", owner, w);
    chk("issue_busy", busy, 1'b1);
    chk("issue_we", bus_we, we_e);
    chk("issue_addr", bus_addr, a_e);
    chk("issue_data", bus_wdata, d_e);
    m_last    = w;
    bus_ready = 1'b1;
    bus_rdata = $urandom;
    step();
    k   = 0;
    fin = 1'b0;
    ok  = 1'b0;
    rd  = '0;
    while (!fin) begin
      k++;
      chk("wait_strobe", bus_clk, 1'b0);
      chk("wait_busy", busy, 1'b1);
      chk("wait_we", bus_we, we_e);
      chk("wait_addr", bus_addr, a_e);
      chk("wait_data", bus_wdata, d_e);
      chk("wait_pulses", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
      rd        = $urandom;
      bus_rdata = rd;
      bus_ready = (k == delay + 1);
      ok        = bus_ready;
      fin       = bus_ready || k == TO;
      step();
    end
    bus_ready = 1'b0;
    if (!ok) m_rd[w] = '0;
    else if (!we_e) m_rd[w] = rd;
    chk("done_m0_ack", m0_ack, ok && !w);
    chk("done_m0_err", m0_err, !ok && !w);
    chk("done_m1_ack", m1_ack, ok && w);
    chk("done_m1_err", m1_err, !ok && w);
    chk("done_m0_rdata", m0_rdata, m_rd[0]);
    chk("done_m1_rdata", m1_rdata, m_rd[1]);
    chk("done_we", bus_we, 1'b0);
    chk("done_owner", owner, w);
    in_done = 1'b1;
  endtask
  initial begin
    logic          p_req [2];
    logic          p_we [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    int            dly;
    m_last = 1'b1;
    m_rd   = '{default: '0};
    step();
    step();
    chk("rst_owner", owner, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus", {bus_clk, bus_we, bus_addr, bus_wdata}, 66'd0);
    chk("rst_pulses", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    rst = 1'b0;
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, '0, '0, '0, 0);
    txn(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h200, '0, 32'hA5, 5);
    for (int i = 0; i < 4; i++)
      txn(1'b1, 1'b1, 1'b0, 1'b1, 32'h100 + i, 32'h300 + i, 32'h11 * i, 32'h22 * i, 0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h40, '0, '0, '0, TO);
    txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h44, '0, '0, 1);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 32'h48, '0, '0, '0, TO - 1);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h50; m1_req = 1'b0;
    if (in_done) step();
    step();
    step();
    step();
    rst = 1'b1; m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h60;
    step();
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_owner", owner, 1'b0);
    chk("midrst_pulses", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
    chk("midrst_bus", {bus_clk, bus_we, bus_addr}, 34'd0);
    chk("midrst_rdata", {m0_rdata, m1_rdata}, 64'd0);
    m_last  = 1'b1;
    m_rd    = '{default: '0};
    in_done = 1'b0;
    rst     = 1'b0;
    txn(1'b0, 1'b1, 1'b0, 1'b0, '0, 32'h60, '0, '0, 0);
    p_req = '{default: 1'b0};
    for (int i = 0; i < 30; i++) begin
      for (int m = 0; m < 2; m++) if (!p_req[m]) begin
        p_req[m]  = $urandom_range(0, 2) != 0;
        p_we[m]   = $urandom_range(0, 1) == 1;
        p_addr[m] = $urandom;
        p_data[m] = $urandom;
      end
      if (!p_req[0] && !p_req[1]) p_req[0] = 1'b1;
      dly = $urandom_range(0, 3);
      if ($urandom_range(0, 7) == 0) dly = TO - 1;
      if ($urandom_range(0, 7) == 0) dly = TO;
      if (((p_req[0] && p_req[1]) ? !m_last : p_req[1]) ? p_we[1] : p_we[0]) dly = dly % TO;
      txn(p_req[0], p_req[1], p_we[0], p_we[1], p_addr[0], p_addr[1], p_data[0], p_data[1], dly);
      p_req[m_last] = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
